lcd_mode_arbiter: RTL and testbench

Arbitrates ownership of the shared LCD character path and the debounced switch bank among four display modes: 0 watch, 1 time-set, 2 alarm-set, 3 alarm-ring. Sits between the mode blocks and lcd_driver, replacing a flat combinational dip-switch mux. Mode changes are synchronised to LCD frame boundaries, with one blank frame between owners. Switch pulses go only to the settled owner, so no mode ever sees a pulse during a handoff.

---
 rtl/lcd_mode_arbiter_pkg.sv | 25 ++
 rtl/lcd_mode_arbiter_filter.sv | 54 +++++
 rtl/lcd_mode_arbiter.sv | 140 ++++++++++++++
 tb/tb_lcd_mode_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_mode_arbiter_pkg.sv
// rtl/lcd_mode_arbiter_pkg.sv - shared encodings and constants for the LCD mode arbiter
// Purpose: mode encodings, handoff FSM states, LCD frame constants and the
//          mode_sel mapping helper used by lcd_mode_arbiter and mode_sel_filter.
package lcd_mode_arbiter_pkg;

    localparam logic [1:0] MODE_WATCH = 2'd0;
    localparam logic [1:0] MODE_SET   = 2'd1;
    localparam logic [1:0] MODE_ALARM = 2'd2;
    localparam logic [1:0] MODE_RING  = 2'd3;

    typedef enum logic [1:0] {
        OWN       = 2'd0,
        WAIT_EDGE = 2'd1,
        BLANK     = 2'd2
    } state_e;

    localparam int         LCD_FRAME_LEN  = 32;
    localparam logic [7:0] LCD_BLANK_CHAR = 8'h20;

    // The dip switches can present 2'b11, which is never a selectable mode.
    function automatic logic [1:0] map_mode_sel(input logic [1:0] sel);
        return (sel == 2'b11) ? MODE_WATCH : sel;
    endfunction

endpackage

// File: rtl/lcd_mode_arbiter_filter.sv
// rtl/lcd_mode_arbiter_filter.sv - stability filter for the raw mode_sel dip switches
// Purpose: accepts mode_sel only after it has held for STABLE_CYC cycles.
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   mode_sel_i     raw dip-switch mode request
//   sel_stable_o   last accepted mode (2'b11 mapped to 2'b00)
module mode_sel_filter
    import lcd_mode_arbiter_pkg::*;
#(
    parameter int STABLE_CYC = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] mode_sel_i,
    output logic [1:0] sel_stable_o
);

    localparam int             CW      = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_prev_q, sel_prev_d;
    logic [1:0]    sel_stable_q, sel_stable_d;

    always_comb begin
        cnt_d        = cnt_q;
        sel_prev_d   = mode_sel_i;
        sel_stable_d = sel_stable_q;
        if (mode_sel_i != sel_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            // Counter is saturated: the request has held long enough.
            sel_stable_d = map_mode_sel(mode_sel_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            sel_prev_q   <= '0;
            sel_stable_q <= MODE_WATCH;
        end else begin
            cnt_q        <= cnt_d;
            sel_prev_q   <= sel_prev_d;
            sel_stable_q <= sel_stable_d;
        end
    end

    assign sel_stable_o = sel_stable_q;

endmodule

// File: rtl/lcd_mode_arbiter.sv
// rtl/lcd_mode_arbiter.sv - frame-synchronised owner arbiter for the LCD path and switch bank
// Purpose: hands the LCD character path and switch pulses to one of four modes,
//          changing owner only on LCD frame boundaries with a blank frame between.
// Optional feature macro: ALARM_PREEMPT_EN (alarm_req_i forces mode 3, no blank frame).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mode_sel_i                   raw mode request (2'b11 treated as 2'b00)
//   alarm_req_i                  alarm-ring request level
//   sw_in_i                      debounced switch pulses
//   index_char_i                 character index from lcd_driver
//   data_mode0_i..data_mode3_i   characters from each mode block
//   data_char_o                  registered character to lcd_driver
//   sw_mode0_o..sw_mode3_o       switch pulses routed to each mode block
//   owner_o                      current owning mode
//   switching_o                  high while a handoff is in progress
module lcd_mode_arbiter
    import lcd_mode_arbiter_pkg::*;
#(
    parameter int         STABLE_CYC = 16,
    parameter int         FRAME_LEN  = LCD_FRAME_LEN,
    parameter logic [7:0] BLANK_CHAR = LCD_BLANK_CHAR
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] mode_sel_i,
    input  logic       alarm_req_i,
    input  logic [3:0] sw_in_i,
    input  logic [4:0] index_char_i,
    input  logic [7:0] data_mode0_i,
    input  logic [7:0] data_mode1_i,
    input  logic [7:0] data_mode2_i,
    input  logic [7:0] data_mode3_i,
    output logic [7:0] data_char_o,
    output logic [3:0] sw_mode0_o,
    output logic [3:0] sw_mode1_o,
    output logic [3:0] sw_mode2_o,
    output logic [3:0] sw_mode3_o,
    output logic [1:0] owner_o,
    output logic       switching_o
);

`ifdef ALARM_PREEMPT_EN
    localparam bit PreemptEn = 1'b1;
`else
    localparam bit PreemptEn = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [4:0] prev_index_q;
    logic [7:0] data_char_q, data_char_d;
    logic       switching_q;
    logic [1:0] sel_stable;
    logic [1:0] target;
    logic       preempt;
    logic       frame_edge;
    logic [7:0] owner_data;
    logic       own_settled;

    mode_sel_filter #(
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mode_sel_i   (mode_sel_i),
        .sel_stable_o (sel_stable)
    );

    assign preempt    = PreemptEn && alarm_req_i;
    assign target     = preempt ? MODE_RING : sel_stable;
    assign frame_edge = (index_char_i == 5'd0) && (prev_index_q == 5'(FRAME_LEN - 1));

    always_comb begin
        case (owner_q)
            2'd0:    owner_data = data_mode0_i;
            2'd1:    owner_data = data_mode1_i;
            2'd2:    owner_data = data_mode2_i;
            default: owner_data = data_mode3_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        data_char_d = (state_q == BLANK) ? BLANK_CHAR : owner_data;
        case (state_q)
            OWN: begin
                if (target != owner_q) state_d = WAIT_EDGE;
            end
            WAIT_EDGE: begin
                if (frame_edge) begin
                    if (preempt) begin
                        // Alarm takes the display at once, skipping the blank frame.
                        state_d = OWN;
                        owner_d = MODE_RING;
                    end else begin
                        state_d = BLANK;
                    end
                end
            end
            BLANK: begin
                // Owner is whatever target is now; the blank completes even if
                // target has returned to the previous owner.
                if (frame_edge) begin
                    owner_d = target;
                    state_d = OWN;
                end
            end
            default: state_d = OWN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= OWN;
            owner_q      <= MODE_WATCH;
            prev_index_q <= '0;
            data_char_q  <= BLANK_CHAR;
            switching_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            prev_index_q <= index_char_i;
            data_char_q  <= data_char_d;
            switching_q  <= (state_d != OWN);
        end
    end

    // Switches reach only a settled owner; the cycle leaving OWN still counts.
    assign own_settled = (state_q == OWN);
    assign sw_mode0_o  = (own_settled && owner_q == 2'd0) ? sw_in_i : 4'd0;
    assign sw_mode1_o  = (own_settled && owner_q == 2'd1) ? sw_in_i : 4'd0;
    assign sw_mode2_o  = (own_settled && owner_q == 2'd2) ? sw_in_i : 4'd0;
    assign sw_mode3_o  = (own_settled && owner_q == 2'd3) ? sw_in_i : 4'd0;

    assign data_char_o = data_char_q;
    assign owner_o     = owner_q;
    assign switching_o = switching_q;

endmodule

// File: tb/tb_lcd_mode_arbiter.sv
// tb/tb_lcd_mode_arbiter.sv - self-checking bench for lcd_mode_arbiter
module tb_lcd_mode_arbiter;

    localparam int STABLE = 16;
`ifdef ALARM_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode_sel = 2'b00;
    logic       alarm_req = 1'b0;
    logic [3:0] sw_in = 4'd0;
    logic [4:0] index_char = 5'd0;
    logic [7:0] dm [4];
    logic [7:0] data_char;
    logic [3:0] swm0, swm1, swm2, swm3;
    logic [1:0] owner;
    logic       switching;

    int total = 0;
    int passed = 0;

    // Reference model: owner, number of frame edges still to go before the
    // handoff lands (0 = settled, 2 = waiting for first edge, 1 = blank frame),
    // and how long mode_sel has been held.
    int         m_owner, m_left, m_stable, m_last_ms, m_run, m_prev_idx;
    logic [7:0] m_data;

    always #5 clk = ~clk;

    lcd_mode_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mode_sel_i   (mode_sel),
        .alarm_req_i  (alarm_req),
        .sw_in_i      (sw_in),
        .index_char_i (index_char),
        .data_mode0_i (dm[0]),
        .data_mode1_i (dm[1]),
        .data_mode2_i (dm[2]),
        .data_mode3_i (dm[3]),
        .data_char_o  (data_char),
        .sw_mode0_o   (swm0),
        .sw_mode1_o   (swm1),
        .sw_mode2_o   (swm2),
        .sw_mode3_o   (swm3),
        .owner_o      (owner),
        .switching_o  (switching)
    );

    function automatic logic [3:0] exp_sw(input int n);
        return (m_left == 0 && m_owner == n) ? sw_in : 4'd0;
    endfunction

    // One clock with the inputs currently applied; the model follows the
    // arbiter's rules at the same edge, then the frame index advances.
    task automatic tick();
        int  tgt;
        bit  pre, fe;
        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_left = 0; m_stable = 0; m_last_ms = 0; m_run = 0;
            m_prev_idx = 0; m_data = 8'h20;
        end else begin
            pre = PRE && alarm_req;
            tgt = pre ? 3 : m_stable;
            fe  = (index_char == 0) && (m_prev_idx == 31);
            m_data = (m_left == 1) ? 8'h20 : dm[m_owner];
            if (m_left == 0) begin
                if (tgt != m_owner) m_left = 2;
            end else if (fe) begin
                if (m_left == 2 && pre) begin
                    m_owner = 3;
                    m_left  = 0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_owner = tgt;
                end
            end
            if (int'(mode_sel) != m_last_ms) m_run = 0;
            else m_run = m_run + 1;
            m_last_ms = int'(mode_sel);
            if (m_run >= STABLE) m_stable = (mode_sel == 2'b11) ? 0 : int'(mode_sel);
            m_prev_idx = int'(index_char);
        end
        #1;
        index_char = index_char + 5'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (owner !== 2'd0) $display("FAIL reset_owner: got %0d expected 0", owner); else passed++;
        total++;
        if (switching !== 1'b0) $display("FAIL reset_switching: got %0b expected 0", switching); else passed++;
        total++;
        if (data_char !== 8'h20) $display("FAIL reset_data: got %h expected 20", data_char); else passed++;
    endtask

    task automatic test_basic_own();
        mode_sel = 2'b00;
        dm[0] = 8'h41; dm[1] = 8'h42; dm[2] = 8'h43; dm[3] = 8'h44;
        tick();
        total++;
        if (data_char !== 8'h41) $display("FAIL basic_data: got %h expected 41", data_char); else passed++;
        sw_in = 4'b0001;
        #1;
        total++;
        if (swm0 !== 4'b0001) $display("FAIL basic_sw0: got %b expected 0001", swm0); else passed++;
        total++;
        if ({swm1, swm2, swm3} !== 12'd0) $display("FAIL basic_sw_other: got %h expected 000", {swm1, swm2, swm3}); else passed++;
        tick();
        sw_in = 4'd0;
    endtask

    // Runs until the model settles on want_owner, checking every cycle and
    // counting blank characters seen on the output.
    task automatic run_handoff(input string name, input int want_owner, input int want_blanks);
        int  blanks = 0;
        bit  done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            total++;
            if (owner !== 2'(m_owner) || switching !== (m_left != 0) || data_char !== m_data) begin
                $display("FAIL %s_cycle%0d: got owner=%0d sw=%0b data=%h expected owner=%0d sw=%0b data=%h",
                         name, i, owner, switching, data_char, m_owner, (m_left != 0), m_data);
            end else passed++;
            if (data_char === 8'h20) blanks++;
            if (m_owner == want_owner && m_left == 0 && i > 0) done = 1'b1;
        end
        total++;
        if (!done) $display("FAIL %s_timeout: got owner=%0d expected %0d", name, owner, want_owner); else passed++;
        total++;
        if (blanks != want_blanks) $display("FAIL %s_blank_frame: got %0d blank chars expected %0d", name, blanks, want_blanks); else passed++;
        total++;
        if (owner !== 2'(want_owner)) $display("FAIL %s_owner: got %0d expected %0d", name, owner, want_owner); else passed++;
    endtask

    task automatic test_handoff();
        mode_sel = 2'b01;
        run_handoff("handoff_0_to_1", 1, 32);
    endtask

    task automatic test_glitch();
        mode_sel = 2'b10;
        for (int i = 0; i < 15; i++) tick();
        mode_sel = 2'b01;
        for (int i = 0; i < 60; i++) begin
            tick();
            total++;
            if (switching !== 1'b0 || owner !== 2'd1)
                $display("FAIL glitch_%0d: got owner=%0d sw=%0b expected owner=1 sw=0", i, owner, switching);
            else passed++;
        end
    endtask

    task automatic test_sw_blank();
        bit seen = 1'b0;
        mode_sel = 2'b00;
        for (int i = 0; i < 200 && m_left != 1; i++) tick();
        sw_in = 4'b0100;
        #1;
        total++;
        if (m_left != 1 || {swm0, swm1, swm2, swm3} !== 16'd0)
            $display("FAIL sw_blank_gate: got %h expected 0000", {swm0, swm1, swm2, swm3});
        else passed++;
        tick();
        sw_in = 4'd0;
        for (int i = 0; i < 80; i++) begin
            tick();
            #1;
            total++;
            if ({swm0, swm1, swm2, swm3} !== 16'd0) $display("FAIL sw_no_replay_%0d: got %h expected 0000", i, {swm0, swm1, swm2, swm3});
            else passed++;
            if (owner === 2'd0 && switching === 1'b0) seen = 1'b1;
        end
        total++;
        if (!seen) $display("FAIL sw_blank_owner: got owner=%0d expected 0", owner); else passed++;
    endtask

`ifdef ALARM_PREEMPT_EN
    task automatic test_alarm();
        alarm_req = 1'b1;
        run_handoff("alarm_preempt", 3, 0);
        alarm_req = 1'b0;
        run_handoff("alarm_release", 0, 32);
    endtask
`else
    task automatic test_alarm();
        alarm_req = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            total++;
            if (owner !== 2'd0 || switching !== 1'b0)
                $display("FAIL alarm_ignored_%0d: got owner=%0d sw=%0b expected owner=0 sw=0", i, owner, switching);
            else passed++;
        end
        alarm_req = 1'b0;
        mode_sel = 2'b11;
        for (int i = 0; i < 80; i++) tick();
        total++;
        if (owner !== 2'd0 || switching !== 1'b0) $display("FAIL sel11_maps_0: got owner=%0d sw=%0b expected owner=0 sw=0", owner, switching);
        else passed++;
        mode_sel = 2'b00;
    endtask
`endif

    task automatic test_reset_mid();
        mode_sel = 2'b10;
        for (int i = 0; i < 300 && m_left != 1; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (switching !== 1'b1) $display("FAIL rst_mid_precond: got sw=%0b expected 1", switching); else passed++;
        mode_sel = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (owner !== 2'd0 || switching !== 1'b0 || data_char !== 8'h20)
            $display("FAIL rst_mid_state: got owner=%0d sw=%0b data=%h expected owner=0 sw=0 data=20", owner, switching, data_char);
        else passed++;
        dm[0] = 8'h5A;
        tick();
        total++;
        if (data_char !== 8'h5A) $display("FAIL rst_mid_track: got %h expected 5a", data_char); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 4; k++) dm[k] = 8'($urandom);
            sw_in = 4'($urandom);
            if ($urandom_range(0, 39) == 0) mode_sel = 2'($urandom);
            if ($urandom_range(0, 149) == 0) alarm_req = ~alarm_req;
            rst = ($urandom_range(0, 999) == 0);
            #1;
            total++;
            if (swm0 !== exp_sw(0) || swm1 !== exp_sw(1) || swm2 !== exp_sw(2) || swm3 !== exp_sw(3))
                $display("FAIL rand_sw_%0d: got %h expected %h", i, {swm0, swm1, swm2, swm3},
                         {exp_sw(0), exp_sw(1), exp_sw(2), exp_sw(3)});
            else passed++;
            tick();
            total++;
            if (owner !== 2'(m_owner) || switching !== (m_left != 0) || data_char !== m_data)
                $display("FAIL rand_out_%0d: got owner=%0d sw=%0b data=%h expected owner=%0d sw=%0b data=%h",
                         i, owner, switching, data_char, m_owner, (m_left != 0), m_data);
            else passed++;
        end
        rst = 1'b0;
        sw_in = 4'd0;
    endtask

    initial begin
        dm[0] = 8'h41; dm[1] = 8'h42; dm[2] = 8'h43; dm[3] = 8'h44;
        test_reset();
        test_basic_own();
        test_handoff();
        test_glitch();
        test_sw_blank();
        test_alarm();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
